// File: rtl/neuron_backprop_collector.sv
// ---------------------------------------------------------------------------
// neuron_backprop_collector
//
// Serial backward-path aggregator. It takes one neuron's expected_in vector
// per accepted beat and sums the vectors element by element. After NEURONS
// beats it registers the element-wise average and holds it on out_vec until
// the consumer takes it.
//
// Optional feature: define BACKPROP_ROUND_EN to round the average half-up,
// computed as (acc + NEURONS/2) / NEURONS. When it is undefined (the default),
// the average is truncated: acc / NEURONS.
//
// Parameters
//   NEURONS  vectors averaged per result (beats per frame), >= 1
//   LEN      elements per vector
//   DATA_W   element width, equal to $bits(zero2one_t), treated as unsigned
//
// Ports
//   clock       rising-edge clock
//   reset       synchronous, active-high
//   in_valid    a beat is present on in_vec
//   in_ready    the collector accepts a beat this cycle
//   in_vec      one neuron's expected_in vector (LEN x DATA_W)
//   out_valid   the averaged vector is valid
//   out_ready   the consumer takes out_vec this cycle
//   out_vec     element-wise average of NEURONS beats
//   beat_count  beats accepted in the current frame
// ---------------------------------------------------------------------------
module neuron_backprop_collector #(
    parameter int NEURONS = 14,
    parameter int LEN     = 16,
    parameter int DATA_W  = 8,
    localparam int CW     = $clog2(NEURONS + 1)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LEN-1:0][DATA_W-1:0]   in_vec,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LEN-1:0][DATA_W-1:0]   out_vec,
    output logic [CW-1:0]                beat_count
);

    // The sum of NEURONS values of DATA_W bits each fits in DATA_W + CW bits.
    localparam int AW = DATA_W + CW;

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t state, state_next;

    logic [LEN-1:0][AW-1:0] acc_p0;
    logic [LEN-1:0][AW-1:0] sum;
    logic                   accept;
    logic                   last_beat;
    logic                   fire;

    // Average of one accumulated element. The quotient is a mean of DATA_W-bit
    // values, so it always fits back into DATA_W bits without saturation.
    function automatic logic [DATA_W-1:0] mean(input logic [AW-1:0] s);
        logic [AW-1:0] q;
`ifdef BACKPROP_ROUND_EN
        q = (s + AW'(NEURONS / 2)) / AW'(NEURONS);
`else
        q = s / AW'(NEURONS);
`endif
        return q[DATA_W-1:0];
    endfunction

    assign accept    = in_valid && in_ready;
    assign last_beat = accept && (beat_count == CW'(NEURONS - 1));
    assign fire      = out_valid && out_ready;

    // The first beat of a frame loads the accumulator and does not add to it,
    // so a stale sum can never leak into a new frame.
    always_comb begin
        sum = '0;
        for (int e = 0; e < LEN; e++) begin
            sum[e] = ((beat_count == '0) ? AW'(0) : acc_p0[e]) + AW'(in_vec[e]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (last_beat) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (fire) begin
                    state_next = ACCUM;
                end
            end
            default: state_next = ACCUM;
        endcase
    end

    // Accumulate stage (acc_p0) feeding the registered average (out_vec).
    always_ff @(posedge clock) begin
        if (reset) begin
            beat_count <= '0;
            acc_p0     <= '0;
            out_vec    <= '0;
        end else if (accept) begin
            acc_p0 <= sum;
            if (last_beat) begin
                beat_count <= '0;
                for (int e = 0; e < LEN; e++) begin
                    out_vec[e] <= mean(sum[e]);
                end
            end else begin
                beat_count <= beat_count + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_neuron_backprop_collector.sv
module tb_neuron_backprop_collector;

    localparam int NEURONS = 14;
    localparam int LEN     = 16;
    localparam int DATA_W  = 8;
    localparam int CW      = $clog2(NEURONS + 1);

    typedef logic [LEN-1:0][DATA_W-1:0] vec_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    vec_t          in_vec;
    logic          out_valid;
    logic          out_ready;
    vec_t          out_vec;
    logic [CW-1:0] beat_count;

    int tests_run = 0;
    int tests_failed = 0;

    neuron_backprop_collector #(
        .NEURONS (NEURONS),
        .LEN     (LEN),
        .DATA_W  (DATA_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_vec     (in_vec),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_vec    (out_vec),
        .beat_count (beat_count)
    );

    always #5 clock = ~clock;

    function automatic vec_t fill(input logic [DATA_W-1:0] v);
        vec_t r;
        for (int e = 0; e < LEN; e++) r[e] = v;
        return r;
    endfunction

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_vec    = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    // Present one beat and keep in_valid high until it is accepted (bounded).
    task automatic feed_beat(input vec_t v);
        int waited;
        in_valid = 1'b1;
        in_vec   = v;
        waited   = 0;
        @(negedge clock);
        while (!in_ready && waited < 50) begin
            @(negedge clock);
            waited++;
        end
        if (!in_ready) begin
            tests_run++;
            tests_failed++;
            $display("FAIL feed_beat_timeout: in_ready=%0b required 1", in_ready);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic consume();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clock);
        #1 out_ready = 1'b0;
    endtask

    task automatic check_result(input string name, input vec_t exp);
        tests_run++;
        if (out_valid !== 1'b1 || out_vec !== exp) begin
            tests_failed++;
            $display("FAIL %s: out_valid=%0b out_vec=%h required 1 / %h", name, out_valid, out_vec, exp);
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clock);
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || beat_count !== '0 || out_vec !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: in_ready=%0b out_valid=%0b beat_count=%0d out_vec=%h required 1 0 0 0",
                     in_ready, out_valid, beat_count, out_vec);
        end
    endtask

    task automatic test_constant();
        do_reset();
        for (int k = 0; k < NEURONS; k++) begin
            in_valid = 1'b1;
            in_vec   = fill(8'd10);
            @(negedge clock);
            tests_run++;
            if (beat_count !== CW'(k) || out_valid !== 1'b0 || in_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL const_beat%0d: beat_count=%0d out_valid=%0b in_ready=%0b required %0d 0 1",
                         k, beat_count, out_valid, in_ready, k);
            end
            @(posedge clock);
            #1;
        end
        // in_valid remains high: output must be presented with in_ready low.
        check_result("const_avg", fill(8'd10));
        tests_run++;
        if (in_ready !== 1'b0 || beat_count !== '0) begin
            tests_failed++;
            $display("FAIL const_hold_ctrl: in_ready=%0b beat_count=%0d required 0 0", in_ready, beat_count);
        end
        consume();
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL const_release: out_valid=%0b in_ready=%0b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_ramp();
        vec_t v;
        vec_t exp;
        do_reset();
        for (int k = 0; k < NEURONS; k++) begin
            v    = '0;
            v[0] = DATA_W'(k);
            feed_beat(v);
        end
        exp = '0;
`ifdef BACKPROP_ROUND_EN
        exp[0] = 8'd7;
`else
        exp[0] = 8'd6;
`endif
        check_result("ramp_avg", exp);
        consume();
    endtask

    task automatic test_all_ones();
        do_reset();
        for (int k = 0; k < NEURONS; k++) feed_beat(fill(8'hFF));
        check_result("all_ones_avg", fill(8'hFF));
        consume();
    endtask

    task automatic test_hold_stall();
        vec_t v;
        vec_t exp;
        do_reset();
        for (int e = 0; e < LEN; e++) v[e] = DATA_W'(e * 3);
        exp = v;
        for (int k = 0; k < NEURONS; k++) feed_beat(v);
        in_valid = 1'b1;
        in_vec   = fill(8'd99);
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            check_result("stall_vec", exp);
            tests_run++;
            if (in_ready !== 1'b0 || beat_count !== '0) begin
                tests_failed++;
                $display("FAIL stall_ctrl%0d: in_ready=%0b beat_count=%0d required 0 0", c, in_ready, beat_count);
            end
        end
        @(posedge clock);
        #1 consume();
        for (int k = 0; k < NEURONS; k++) feed_beat(fill(8'd5));
        check_result("stall_next_frame", fill(8'd5));
        consume();
    endtask

    task automatic test_reset_midframe();
        do_reset();
        for (int k = 0; k < 7; k++) feed_beat(fill(8'd200));
        do_reset();
        @(negedge clock);
        tests_run++;
        if (beat_count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL midreset_ctrl: beat_count=%0d out_valid=%0b in_ready=%0b required 0 0 1",
                     beat_count, out_valid, in_ready);
        end
        @(posedge clock);
        #1;
        for (int k = 0; k < NEURONS; k++) feed_beat(fill(8'd3));
        check_result("midreset_avg", fill(8'd3));
        consume();
    endtask

    task automatic test_gaps();
        int  cnt;
        int  cycles;
        logic acc;
        do_reset();
        cnt    = 0;
        cycles = 0;
        in_vec = fill(8'd10);
        while (cnt < NEURONS && cycles < 300) begin
            in_valid = 1'($urandom_range(0, 1));
            @(negedge clock);
            tests_run++;
            if (beat_count !== CW'(cnt)) begin
                tests_failed++;
                $display("FAIL gaps_count: beat_count=%0d required %0d", beat_count, cnt);
            end
            acc = in_valid && in_ready;
            @(posedge clock);
            #1;
            if (acc) cnt++;
            cycles++;
        end
        in_valid = 1'b0;
        tests_run++;
        if (cnt != NEURONS) begin
            tests_failed++;
            $display("FAIL gaps_timeout: beats=%0d required %0d", cnt, NEURONS);
        end
        check_result("gaps_avg", fill(8'd10));
        consume();
    endtask

    initial begin
        test_reset();
        test_constant();
        test_ramp();
        test_all_ones();
        test_hold_stall();
        test_reset_midframe();
        test_gaps();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
